// File: rtl/line_scroll_buffer_pkg.sv
// Shared screen and line-buffer constants. The line generator, the scroll
// buffer and the VGA timing block all import this package so they agree.
package line_scroll_buffer_pkg;

  localparam int LINE_W    = 640;  // bits per line, bit x = pixel column x
  localparam int ROWS      = 15;   // screen rows held in the ring buffer
  localparam int ROW_SHIFT = 5;    // log2 of row height in pixels
  localparam int PTR_W     = 4;    // row pointer width, 2^PTR_W >= ROWS

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;

  localparam int COORD_W   = 10;   // width of pixel x/y coordinates

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/line_ring_mem.sv
// ROWS x LINE_W row storage: one write port and one registered read port.
// Reading and writing the same row on one edge returns the old contents.
module line_ring_mem #(
  parameter int LINE_W = line_scroll_buffer_pkg::LINE_W,
  parameter int ROWS   = line_scroll_buffer_pkg::ROWS,
  parameter int PTR_W  = line_scroll_buffer_pkg::PTR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

  logic [LINE_W-1:0] rows [ROWS];

  // Row storage with synchronous clear; reads outside the ring return zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        rows[PTR_W'(i)] <= '0;
      end
      rdata_o <= '0;
    end else begin
      if (we_i && (waddr_i <= LAST_ROW)) begin
        rows[waddr_i] <= wdata_i;
      end
      rdata_o <= (raddr_i <= LAST_ROW) ? rows[raddr_i] : '0;
    end
  end

endmodule

// File: rtl/line_scroll_buffer.sv
// Consumer end of the line stream: buffers one pending line, inserts it at
// the top of the screen on each scroll pulse, and answers pixel queries from
// the renderer with a fixed two-cycle latency.
module line_scroll_buffer #(
  parameter int LINE_W    = line_scroll_buffer_pkg::LINE_W,
  parameter int ROWS      = line_scroll_buffer_pkg::ROWS,
  parameter int ROW_SHIFT = line_scroll_buffer_pkg::ROW_SHIFT,
  parameter int PTR_W     = line_scroll_buffer_pkg::PTR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              line_valid_i,
  output logic              line_ready_o,
  input  logic              scroll_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic              pix_o,
  output logic              underrun_o,
  output logic [PTR_W-1:0]  top_o
);

  import line_scroll_buffer_pkg::*;

  localparam int SUM_W = COORD_W + 1;

  localparam coord_t                ROWS_Y   = COORD_W'(ROWS);
  localparam coord_t                LINE_W_X = COORD_W'(LINE_W);
  localparam logic [SUM_W-1:0]      ROWS_SUM = SUM_W'(ROWS);
  localparam logic [PTR_W-1:0]      LAST_ROW = PTR_W'(ROWS - 1);

  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  top_next;
  logic [LINE_W-1:0] pending;
  logic              pending_full;
  logic              accept;
  logic [LINE_W-1:0] wdata;
  logic              underrun_q;

  coord_t            srow;
  logic              in_range;
  logic [SUM_W-1:0]  phys_sum;
  logic [PTR_W-1:0]  phys;

  logic              in_range_q;
  coord_t            x_q;
  logic [LINE_W-1:0] row_q;
  logic              pix_q;

  // Next top pointer, inserted row contents and handshake acceptance.
  always_comb begin
    top_next = (top_ptr == '0) ? LAST_ROW : top_ptr - PTR_W'(1);
    wdata    = pending_full ? pending : '0;
    accept   = line_valid_i & ~pending_full;
  end

  // Query decode: screen row, range check and wrap to a physical row index.
  always_comb begin
    srow     = y_i >> ROW_SHIFT;
    in_range = (srow < ROWS_Y) && (x_i < LINE_W_X);
    phys_sum = {1'b0, srow} + SUM_W'(top_ptr);
    phys     = (phys_sum >= ROWS_SUM) ? PTR_W'(phys_sum - ROWS_SUM)
                                      : PTR_W'(phys_sum);
  end

  // Stage 1 registers the physical row inside the memory read port rather
  // than as an index here; the row arrives on the same edge either way.
  line_ring_mem #(
    .LINE_W (LINE_W),
    .ROWS   (ROWS),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (scroll_i),
    .waddr_i (top_next),
    .wdata_i (wdata),
    .raddr_i (phys),
    .rdata_o (row_q)
  );

  // Top pointer, pending line register and underrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_ptr      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      underrun_q <= scroll_i & ~pending_full;
      if (scroll_i) begin
        top_ptr      <= top_next;
        pending_full <= 1'b0;
      end
      // A same-cycle accept refills the slot the scroll just emptied.
      if (accept) begin
        pending      <= line_i;
        pending_full <= 1'b1;
      end
    end
  end

  // Pixel pipeline: stage 1 column/range, stage 2 bit select.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_range_q <= 1'b0;
      x_q        <= '0;
      pix_q      <= 1'b0;
    end else begin
      in_range_q <= in_range;
      x_q        <= x_i;
      pix_q      <= in_range_q ? row_q[x_q] : 1'b0;
    end
  end

  assign line_ready_o = ~pending_full;
  assign pix_o        = pix_q;
  assign underrun_o   = underrun_q;
  assign top_o        = top_ptr;

endmodule

// File: tb/tb_line_scroll_buffer.sv
// Bench for line_scroll_buffer: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_line_scroll_buffer;

  localparam int LW = 640;
  localparam int NR = 15;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [LW-1:0] line_i = '0;
  logic          line_valid_i = 1'b0;
  logic          line_ready_o;
  logic          scroll_i = 1'b0;
  logic [9:0]    x_i = '0;
  logic [9:0]    y_i = '0;
  logic          pix_o;
  logic          underrun_o;
  logic [3:0]    top_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  line_scroll_buffer #(
    .LINE_W    (640),
    .ROWS      (15),
    .ROW_SHIFT (5),
    .PTR_W     (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .line_i       (line_i),
    .line_valid_i (line_valid_i),
    .line_ready_o (line_ready_o),
    .scroll_i     (scroll_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .pix_o        (pix_o),
    .underrun_o   (underrun_o),
    .top_o        (top_o)
  );

  // Behavioural model: screen as an array of rows, top index with modulo wrap.
  logic [LW-1:0] m_mem [NR];
  int            m_top;
  logic [LW-1:0] m_pend;
  bit            m_full;
  bit            m_stage;
  bit            m_pix;
  bit            m_under;
  bit            m_live = 0;
  int            m_srow;
  bit            m_acc;

  always @(posedge clk_i) begin
    if (rst_i === 1'b1) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_top   = 0;
      m_pend  = '0;
      m_full  = 0;
      m_stage = 0;
      m_pix   = 0;
      m_under = 0;
      m_live  = 1;
    end else if (m_live) begin
      m_pix  = m_stage;
      m_srow = int'(y_i) / 32;
      if (m_srow < NR && int'(x_i) < LW)
        m_stage = m_mem[(m_top + m_srow) % NR][int'(x_i)];
      else
        m_stage = 0;
      m_under = scroll_i && !m_full;
      m_acc   = line_valid_i && !m_full;
      if (scroll_i) begin
        m_top = (m_top + NR - 1) % NR;
        m_mem[m_top] = m_full ? m_pend : '0;
        m_full = 0;
      end
      if (m_acc) begin
        m_pend = line_i;
        m_full = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_i) begin
    if (m_live) begin
      check("pix_o",        {31'b0, pix_o},        {31'b0, m_pix});
      check("underrun_o",   {31'b0, underrun_o},   {31'b0, m_under});
      check("line_ready_o", {31'b0, line_ready_o}, {31'b0, !m_full});
      check("top_o",        {28'b0, top_o},        m_top);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic load(input logic [LW-1:0] l);
    line_i = l;
    line_valid_i = 1'b1;
    tick();
    line_valid_i = 1'b0;
  endtask

  task automatic scroll();
    scroll_i = 1'b1;
    tick();
    scroll_i = 1'b0;
  endtask

  task automatic query(input int x, input int y, input bit exp, input string name);
    x_i = 10'(x);
    y_i = 10'(y);
    tick();
    tick();
    check(name, {31'b0, pix_o}, {31'b0, exp});
  endtask

  function automatic logic [LW-1:0] one_hot(input int k);
    logic [LW-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [LW-1:0] l;

    // Reset state
    do_reset();
    check("rst_ready", {31'b0, line_ready_o}, 32'd1);
    check("rst_top",   {28'b0, top_o},        32'd0);
    check("rst_pix",   {31'b0, pix_o},        32'd0);

    // Scroll with nothing pending
    scroll();
    check("underrun_empty", {31'b0, underrun_o}, 32'd1);
    check("top_after_1",    {28'b0, top_o},      32'd14);
    query(5, 0, 0, "empty_row_pix");
    query(100, 200, 0, "empty_row_pix2");

    // Single line with bit 5 set
    load(one_hot(5));
    check("ready_low_after_accept", {31'b0, line_ready_o}, 32'd0);
    scroll();
    check("ready_high_after_scroll", {31'b0, line_ready_o}, 32'd1);
    check("no_underrun_with_line",   {31'b0, underrun_o},   32'd0);
    query(5, 0, 1, "bit5_x5y0");
    query(6, 0, 0, "bit5_x6y0");
    query(5, 32, 0, "bit5_x5y32");

    // Sixteen one-hot lines, wrapping the ring
    do_reset();
    for (int k = 0; k < 16; k++) begin
      load(one_hot(k));
      scroll();
    end
    check("top_wrap_16", {28'b0, top_o}, 32'd14);
    query(15, 0, 1, "ring_x15y0");
    query(14, 32, 1, "ring_x14y32");
    query(0, 448, 0, "ring_overwritten_x0y448");
    query(1, 448, 1, "ring_x1y448");

    // Simultaneous scroll and accept with pending empty
    line_i = one_hot(7);
    line_valid_i = 1'b1;
    scroll_i = 1'b1;
    tick();
    line_valid_i = 1'b0;
    scroll_i = 1'b0;
    check("simul_underrun", {31'b0, underrun_o},   32'd1);
    check("simul_ready",    {31'b0, line_ready_o}, 32'd0);
    query(7, 0, 0, "simul_zero_row");
    scroll();
    check("simul_next_no_underrun", {31'b0, underrun_o}, 32'd0);
    query(7, 0, 1, "simul_captured_row");

    // Scroll while pending full and valid held high
    load(one_hot(9));
    line_i = one_hot(10);
    line_valid_i = 1'b1;
    scroll_i = 1'b1;
    tick();
    scroll_i = 1'b0;
    check("full_scroll_ready_rises", {31'b0, line_ready_o}, 32'd1);
    line_valid_i = 1'b0;
    query(9, 0, 1, "full_scroll_row");

    // All rows ones, out-of-range queries
    for (int k = 0; k < NR; k++) begin
      load('1);
      scroll();
    end
    query(639, 479, 1, "ones_last_pixel");
    query(640, 0, 0, "oor_x640");
    query(0, 480, 0, "oor_y480");
    query(1023, 1023, 0, "oor_max");

    // Reset mid-stream with pending full and a query in flight
    load('1);
    x_i = 10'd3;
    y_i = 10'd0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_ready", {31'b0, line_ready_o}, 32'd1);
    check("midrst_top",   {28'b0, top_o},        32'd0);
    check("midrst_pix",   {31'b0, pix_o},        32'd0);
    for (int r = 0; r < NR; r++) begin
      query((r * 41) % LW, r * 32, 0, "midrst_row_clear");
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < LW / 32; w++) l[w*32 +: 32] = $urandom;
      line_i       = l;
      rst_i        = ($urandom_range(0, 499) == 0);
      line_valid_i = $urandom_range(0, 1) == 1;
      scroll_i     = ($urandom_range(0, 3) == 0);
      x_i          = 10'($urandom_range(0, 700));
      y_i          = 10'($urandom_range(0, 520));
      tick();
    end
    rst_i = 1'b0;
    line_valid_i = 1'b0;
    scroll_i = 1'b0;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
